seg_capture: RTL and testbench
==============================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter: STABLE_CNT, default 3, consecutive identical samples (2..15) required to accept a digit.
REQ-002 Port: clk  input  1  system clock, all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: sample_en  input  1  sample strobe; inputs below are evaluated only in cycles where it is high.
REQ-005 Port: seg_in  input  7  observed segment pattern, active-high, bit0=a ... bit6=g.
REQ-006 Port: dot_in  input  1  observed decimal-point segment, active-high.
REQ-007 Port: dig_sel  input  4  observed digit enable, one-hot active-high, bit3 = leftmost digit.
REQ-008 Port: code_out  output  16  last complete frame, 4 codes; digit3 in [15:12], digit0 in [3:0].
REQ-009 Port: frame_valid  output  1  one-cycle pulse, code_out updated.
REQ-010 Port: err_out  output  1  error flag for the frame published with the latest frame_valid.
REQ-011 Port: dot_out  output  4  per-digit decimal point of the last frame (SEG_CAPTURE_DOT_EN only).

Function
REQ-012 Pattern-to-code map, fixed: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9, 0x40->4'hE (minus), 0x00->4'hF (blank).
REQ-013 Any other pattern decodes to 4'hF and marks the pattern invalid.
REQ-014 FSM states: IDLE (no candidate), TRACK (candidate held, stability counting); 2-bit state register.
REQ-015 IDLE: sample_en with one-hot dig_sel -> latch {dig_sel, seg_in, dot_in} as candidate, count=1, go TRACK.
REQ-016 TRACK: sample_en with identical {dig_sel, seg_in, dot_in} -> count+1; count saturates, never wraps.
REQ-017 TRACK: sample_en with differing inputs and one-hot dig_sel -> restart candidate with new value, count=1, stay TRACK.
REQ-018 Acceptance at the edge where count reaches STABLE_CNT: decoded code written into shadow slot of selected digit, digit mask bit set; further identical samples do not re-accept.
REQ-019 Re-acceptance of an already-masked digit before frame completion overwrites its shadow slot; not an error.
REQ-020 dig_sel == 0 at sample_en: blanking; clears candidate, go IDLE; no error.
REQ-021 dig_sel multi-hot at sample_en: clears candidate, go IDLE, sets frame error flag.
REQ-022 Accepting an invalid pattern (REQ-013) sets the frame error flag.
REQ-023 Mask reaching 4'b1111 at an edge: same edge loads code_out from shadow (including the just-accepted digit), err_out from frame error flag (including same-edge errors), asserts frame_valid for exactly the next cycle, clears mask and frame error flag.
REQ-024 Latency: frame_valid high in the cycle after the STABLE_CNT-th matching sample of the fourth distinct digit.
REQ-025 A sample arriving in the cycle frame_valid is high is processed normally and counts toward the next frame.
REQ-026 sample_en low: all state holds; frame_valid still deasserts after one cycle.
REQ-027 code_out, err_out, dot_out hold between frames.

Reset
REQ-028 rst high at a clock edge: state IDLE, count 0, mask 0, shadow 16'hFFFF, frame error 0, code_out 16'hFFFF, frame_valid 0, err_out 0, dot_out 0.
REQ-029 Reset mid-frame discards partial frame; no frame_valid emitted for it; rst overrides all same-cycle inputs.

Configuration
REQ-030 Macro SEG_CAPTURE_DOT_EN defined: dot_in captured per digit on acceptance, published on dot_out with frame; dot_in participates in REQ-016 comparison.
REQ-031 Macro undefined: dot_out port absent, dot_in ignored (not compared), no dot storage.

Verification
REQ-032 STABLE_CNT=3, digits 3..0 each shown 3 samples: 0x06,0x5B,0x4F,0x66 -> code_out 16'h1234, frame_valid one cycle, err_out 0.
REQ-033 Digit2 pattern 0x5B with 2 samples, then 0x4F for 3 -> shadow digit2 = 3; only 3rd 0x4F sample accepts.
REQ-034 Frame containing 0x40,0x00,0x7F,0x6F -> code_out 16'hEF89, err_out 0.
REQ-035 Digit1 pattern 0x11 stable -> nibble [7:4]=F, err_out 1; next clean frame -> err_out 0.
REQ-036 dig_sel 4'b0110 at sample_en mid-frame -> no acceptance, err_out 1 at frame publish; dig_sel 0 between digits -> no error.
REQ-037 rst after 3 digits accepted, then one full frame -> single frame_valid, code_out from post-reset frame only; with SEG_CAPTURE_DOT_EN, dot on digit0 -> dot_out 4'b0001.

Source files
------------

// File: rtl/seg_capture.sv
// Seven-segment display scraper: debounces multiplexed segment/digit-enable samples into a 4-digit code frame.
// Optional define SEG_CAPTURE_DOT_EN adds per-digit decimal-point capture and the dot_out port.
module seg_capture #(
  parameter int unsigned STABLE_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [6:0]  seg_in,
  input  logic        dot_in,
  input  logic [3:0]  dig_sel,
  output logic [15:0] code_out,
  output logic        frame_valid,
  output logic        err_out
`ifdef SEG_CAPTURE_DOT_EN
  ,
  output logic [3:0]  dot_out
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1} state_e;

  localparam logic [3:0] ACC_AT = 4'(STABLE_CNT - 1);

  state_e      state_q;
  logic [3:0]  cnt_q, cand_sel_q, mask_q;
  logic [6:0]  cand_seg_q;
  logic [15:0] shadow_q, code_q;
  logic        ferr_q, err_q, fv_q;

  // {invalid, code}
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = {1'b0, 4'h0};
      7'h06:   decode = {1'b0, 4'h1};
      7'h5B:   decode = {1'b0, 4'h2};
      7'h4F:   decode = {1'b0, 4'h3};
      7'h66:   decode = {1'b0, 4'h4};
      7'h6D:   decode = {1'b0, 4'h5};
      7'h7D:   decode = {1'b0, 4'h6};
      7'h07:   decode = {1'b0, 4'h7};
      7'h7F:   decode = {1'b0, 4'h8};
      7'h6F:   decode = {1'b0, 4'h9};
      7'h40:   decode = {1'b0, 4'hE};
      7'h00:   decode = {1'b0, 4'hF};
      default: decode = {1'b1, 4'hF};
    endcase
  endfunction

  logic        onehot, multihot, match, accept, inv, publish, ferr_nx;
  logic [3:0]  code_dec, mask_nx;
  logic [15:0] shadow_nx;

`ifdef SEG_CAPTURE_DOT_EN
  logic       cand_dot_q;
  logic [3:0] shdot_q, dot_q, shdot_nx;
  assign match = ({cand_sel_q, cand_seg_q, cand_dot_q} == {dig_sel, seg_in, dot_in});
  assign dot_out = dot_q;
`else
  logic unused_dot;
  assign unused_dot = dot_in;
  assign match = ({cand_sel_q, cand_seg_q} == {dig_sel, seg_in});
`endif

  assign onehot   = (dig_sel != 4'd0) && ((dig_sel & (dig_sel - 4'd1)) == 4'd0);
  assign multihot = (dig_sel != 4'd0) && !onehot;
  assign {inv, code_dec} = decode(seg_in);
  // Exactly one sample per candidate run lands on ACC_AT, so re-acceptance can't repeat.
  assign accept  = sample_en && onehot && (state_q == TRACK) && match && (cnt_q == ACC_AT);
  assign mask_nx = mask_q | (accept ? dig_sel : 4'd0);
  assign ferr_nx = ferr_q | (sample_en && multihot) | (accept && inv);
  assign publish = (mask_nx == 4'hF);

  always_comb begin
    shadow_nx = shadow_q;
    for (int i = 0; i < 4; i++)
      if (accept && dig_sel[i]) shadow_nx[i*4 +: 4] = code_dec;
  end

`ifdef SEG_CAPTURE_DOT_EN
  assign shdot_nx = accept ? ((shdot_q & ~dig_sel) | (dot_in ? dig_sel : 4'd0)) : shdot_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      cand_sel_q <= 4'd0;
      cand_seg_q <= 7'd0;
      mask_q     <= 4'd0;
      shadow_q   <= 16'hFFFF;
      ferr_q     <= 1'b0;
      code_q     <= 16'hFFFF;
      err_q      <= 1'b0;
      fv_q       <= 1'b0;
`ifdef SEG_CAPTURE_DOT_EN
      cand_dot_q <= 1'b0;
      shdot_q    <= 4'd0;
      dot_q      <= 4'd0;
`endif
    end else begin
      fv_q     <= publish;
      shadow_q <= shadow_nx;
      mask_q   <= publish ? 4'd0 : mask_nx;
      ferr_q   <= publish ? 1'b0 : ferr_nx;
`ifdef SEG_CAPTURE_DOT_EN
      shdot_q  <= shdot_nx;
      if (publish) dot_q <= shdot_nx;
`endif
      if (publish) begin
        code_q <= shadow_nx;
        err_q  <= ferr_nx;
      end
      if (sample_en) begin
        if (!onehot) begin
          state_q    <= IDLE;
          cnt_q      <= 4'd0;
          cand_sel_q <= 4'd0;
          cand_seg_q <= 7'd0;
`ifdef SEG_CAPTURE_DOT_EN
          cand_dot_q <= 1'b0;
`endif
        end else if (state_q == TRACK && match) begin
          if (cnt_q != 4'd15) cnt_q <= cnt_q + 4'd1;
        end else begin
          state_q    <= TRACK;
          cnt_q      <= 4'd1;
          cand_sel_q <= dig_sel;
          cand_seg_q <= seg_in;
`ifdef SEG_CAPTURE_DOT_EN
          cand_dot_q <= dot_in;
`endif
        end
      end
    end
  end

  assign code_out    = code_q;
  assign frame_valid = fv_q;
  assign err_out     = err_q;

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: directed frames plus randomized sampling against a run-length reference model.
module tb_seg_capture;
  localparam int S = 3;
`ifdef SEG_CAPTURE_DOT_EN
  localparam bit DOT = 1'b1;
`else
  localparam bit DOT = 1'b0;
`endif

  localparam logic [6:0] PATS  [12] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h00};
  localparam logic [3:0] CODES [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hE, 4'hF};

  logic clk = 1'b0;
  logic rst, sample_en, dot_in;
  logic [6:0] seg_in;
  logic [3:0] dig_sel;
  logic [15:0] code_out;
  logic frame_valid, err_out;
`ifdef SEG_CAPTURE_DOT_EN
  logic [3:0] dot_out;
`endif

  seg_capture #(.STABLE_CNT(S)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .seg_in(seg_in), .dot_in(dot_in),
    .dig_sel(dig_sel), .code_out(code_out), .frame_valid(frame_valid), .err_out(err_out)
`ifdef SEG_CAPTURE_DOT_EN
    , .dot_out(dot_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, fv_seen = 0;

  // Reference model: runs of identical samples counted as plain integers.
  bit         m_have;
  logic [3:0] m_cs;
  logic [6:0] m_cg;
  logic       m_cd;
  int         m_run;
  bit [3:0]   m_mask, m_shd, m_dot;
  logic [3:0] m_sh [4];
  bit         m_ferr, m_err, m_fv;
  logic [15:0] m_code;

  function automatic logic [4:0] lookup(input logic [6:0] p);
    for (int i = 0; i < 12; i++) if (PATS[i] == p) return {1'b0, CODES[i]};
    return {1'b1, 4'hF};
  endfunction

  task automatic model_step(input logic r, input logic en, input logic [3:0] sel, input logic [6:0] seg, input logic d);
    logic [4:0] dc;
    int idx;
    bit same;
    m_fv = 1'b0;
    if (r) begin
      m_have = 0; m_run = 0; m_mask = 0; m_ferr = 0; m_code = 16'hFFFF; m_err = 0; m_dot = 0; m_shd = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 4'hF;
    end else if (en) begin
      if ($countones(sel) == 0) begin
        m_have = 0; m_run = 0;
      end else if ($countones(sel) > 1) begin
        m_have = 0; m_run = 0; m_ferr = 1;
      end else begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
        same = m_have && (sel == m_cs) && (seg == m_cg) && (!DOT || d == m_cd);
        if (same) m_run++;
        else begin m_have = 1; m_cs = sel; m_cg = seg; m_cd = d; m_run = 1; end
        if (m_run == S) begin
          dc = lookup(seg);
          m_sh[idx] = dc[3:0]; m_mask[idx] = 1; m_shd[idx] = d;
          if (dc[4]) m_ferr = 1;
          if (m_mask == 4'hF) begin
            m_code = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
            m_err = m_ferr; m_dot = m_shd; m_fv = 1; m_mask = 0; m_ferr = 0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic [3:0] sel, input logic [6:0] seg, input logic d);
    rst = r; sample_en = en; dig_sel = sel; seg_in = seg; dot_in = d;
    @(posedge clk);
    model_step(r, en, sel, seg, d);
    #1;
    if (frame_valid === 1'b1) fv_seen++;
    chk("frame_valid", {15'd0, frame_valid}, {15'd0, m_fv});
    chk("code_out", code_out, m_code);
    chk("err_out", {15'd0, err_out}, {15'd0, m_err});
`ifdef SEG_CAPTURE_DOT_EN
    chk("dot_out", {12'd0, dot_out}, {12'd0, m_dot});
`endif
  endtask

  task automatic show(input logic [3:0] sel, input logic [6:0] seg, input logic d, input int n);
    repeat (n) step(1'b0, 1'b1, sel, seg, d);
  endtask

  initial begin
    logic [3:0] sel;
    logic [6:0] seg;
    logic d;
    int len;

    // Reset state
    step(1'b1, 1'b0, 4'd0, 7'd0, 1'b0);
    step(1'b1, 1'b1, 4'b0001, 7'h06, 1'b1);
    chk("rst_code", code_out, 16'hFFFF);
    chk("rst_fv", {15'd0, frame_valid}, 16'd0);
    step(1'b0, 1'b0, 4'd0, 7'd0, 1'b0);

    // Basic frame 1234
    show(4'b1000, 7'h06, 1'b0, 3); show(4'b0100, 7'h5B, 1'b0, 3);
    show(4'b0010, 7'h4F, 1'b0, 3); show(4'b0001, 7'h66, 1'b0, 3);
    chk("basic_fv_latency", {15'd0, frame_valid}, 16'd1);
    chk("basic_code", code_out, 16'h1234);
    chk("basic_err", {15'd0, err_out}, 16'd0);
    step(1'b0, 1'b0, 4'd0, 7'd0, 1'b0);
    chk("basic_fv_pulse", {15'd0, frame_valid}, 16'd0);
    chk("basic_hold", code_out, 16'h1234);

    // Candidate restart before stability
    show(4'b1000, 7'h06, 1'b0, 3); show(4'b0100, 7'h5B, 1'b0, 2);
    show(4'b0100, 7'h4F, 1'b0, 3); show(4'b0010, 7'h66, 1'b0, 3);
    show(4'b0001, 7'h3F, 1'b0, 3);
    chk("restart_code", code_out, 16'h1340);

    // Minus, blank, 8, 9
    show(4'b1000, 7'h40, 1'b0, 3); show(4'b0100, 7'h00, 1'b0, 3);
    show(4'b0010, 7'h7F, 1'b0, 3); show(4'b0001, 7'h6F, 1'b0, 4);
    chk("special_code", code_out, 16'hEF89);
    chk("special_err", {15'd0, err_out}, 16'd0);

    // Invalid pattern, then clean frame
    show(4'b1000, 7'h06, 1'b0, 3); show(4'b0100, 7'h06, 1'b0, 3);
    show(4'b0010, 7'h11, 1'b0, 3); show(4'b0001, 7'h06, 1'b0, 3);
    chk("invalid_code", code_out, 16'h11F1);
    chk("invalid_err", {15'd0, err_out}, 16'd1);
    show(4'b1000, 7'h06, 1'b0, 3); show(4'b0100, 7'h06, 1'b0, 3);
    show(4'b0010, 7'h06, 1'b0, 3); show(4'b0001, 7'h06, 1'b0, 3);
    chk("clean_err", {15'd0, err_out}, 16'd0);

    // Multi-hot select is an error, zero select is blanking
    show(4'b1000, 7'h7D, 1'b0, 3); show(4'b0110, 7'h07, 1'b0, 3);
    show(4'b0100, 7'h07, 1'b0, 3); show(4'b0000, 7'h00, 1'b0, 2);
    show(4'b0010, 7'h6D, 1'b0, 3); show(4'b0001, 7'h3F, 1'b0, 3);
    chk("multihot_code", code_out, 16'h6750);
    chk("multihot_err", {15'd0, err_out}, 16'd1);
    show(4'b1000, 7'h3F, 1'b0, 3); show(4'b0000, 7'h00, 1'b0, 1);
    show(4'b0100, 7'h06, 1'b0, 3); show(4'b0000, 7'h00, 1'b0, 1);
    show(4'b0010, 7'h5B, 1'b0, 3); show(4'b0000, 7'h00, 1'b0, 1);
    show(4'b0001, 7'h4F, 1'b0, 3);
    chk("blank_code", code_out, 16'h0123);
    chk("blank_err", {15'd0, err_out}, 16'd0);

    // Reset mid-frame discards partial data
    show(4'b1000, 7'h7F, 1'b0, 3); show(4'b0100, 7'h7F, 1'b0, 3); show(4'b0010, 7'h7F, 1'b0, 3);
    step(1'b1, 1'b1, 4'b0001, 7'h7F, 1'b0);
    fv_seen = 0;
    show(4'b1000, 7'h66, 1'b0, 3); show(4'b0100, 7'h6D, 1'b0, 3);
    show(4'b0010, 7'h7D, 1'b0, 3); show(4'b0001, 7'h07, 1'b1, 3);
    step(1'b0, 1'b0, 4'd0, 7'd0, 1'b0);
    chk("rst_frame_count", 16'(fv_seen), 16'd1);
    chk("rst_frame_code", code_out, 16'h4567);
`ifdef SEG_CAPTURE_DOT_EN
    chk("rst_frame_dot", {12'd0, dot_out}, 16'h0001);
`endif

    // Randomized bursts
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 11))
        10:      sel = 4'd0;
        11:      sel = 4'($urandom_range(0, 15));
        default: sel = 4'b1000 >> (k % 4);
      endcase
      seg = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : PATS[$urandom_range(0, 11)];
      d = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 9) == 0)
          step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
        step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0), sel, seg,
             ($urandom_range(0, 5) == 0) ? ~d : d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
